prio_enc_hs: RTL and testbench
==============================

Name: prio_enc_hs

Overview:
Parametrised N-to-log2(N) encoder, the successor to the fixed 8-to-3 encoder. Request bits are captured into a sticky pending register. They are encoded one at a time under a run-time priority mode (fixed-high, fixed-low, round-robin). Each code is delivered through a registered valid/ready output stage, so no request pulse is lost under backpressure. Sits between request sources (interrupt lines, channel flags) and a single consumer that processes one index at a time.

Parameters:
N, 8, number of request inputs; must be >= 2.
W, 3, output code width; must equal clog2(N). Elaboration fails otherwise.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, synchronous, active-low
d  input  N  request bits; any bit high for one clk edge is captured
mode  input  2  0 = highest index wins, 1 = lowest index wins, 2 = round-robin, 3 = treated as 0
out_code  output  W  encoded index of granted request
out_vld  output  1  out_code valid
out_rdy  input  1  consumer accepts out_code when out_vld and out_rdy are high on the same edge
pending  output  N  captured, not-yet-granted requests (registered)
busy  output  1  out_vld OR (pending != 0)

Behaviour:
- Reset (rst_n low at a clk edge):
  - pending = 0, out_vld = 0, out_code = 0, RR pointer last = N-1.
  - d is ignored on that edge.
  - Reset mid-transfer discards any held code and all pending bits.
- load = (out_vld == 0 OR out_rdy == 1) AND (pending != 0). Selection operates on the registered pending only, never on d directly.
- Selection (sel):
  - mode 0: highest set index of pending.
  - mode 1: lowest set index.
  - mode 2: first set index searching last+1, last+2, ... wrapping modulo N.
- On load:
  - out_code <= sel, out_vld <= 1.
  - pending <= (pending AND NOT onehot(sel)) OR d.
  - last <= sel, updated in every mode.
- No load, out_vld AND out_rdy: out_vld <= 0, out_code holds last value, pending <= pending OR d.
- No load otherwise: out_vld and out_code hold; pending <= pending OR d.
- Stability: while out_vld = 1 and out_rdy = 0, out_code must not change.
- Latency and throughput:
  - A d bit at edge t becomes pending after edge t.
  - Earliest out_vld is after edge t+1 (2-cycle latency).
  - Sustained throughput is one code per cycle with out_rdy held high.
- Simultaneous events:
  - A d bit equal to the bit granted on the same edge stays set in pending (set wins over clear); it is granted again later.
  - Repeated d pulses of an already-pending bit merge into one grant.
- mode changes take effect on the next load; an already loaded out_code is not re-evaluated.
- N not a power of 2: codes >= N are never produced.

Test Plan:
1. Reset: d = 0xFF, rst_n low 2 edges -> out_vld = 0, out_code = 0, pending = 0x00, busy = 0 throughout; after release with d = 0, all stay 0.
2. Fixed-high priority: mode = 0, out_rdy = 1, d = 0x24 for one edge at t -> out_vld = 1 with out_code = 5 after t+1, out_code = 2 after t+2, out_vld = 0 after t+3.
3. Fixed-low priority: mode = 1, same stimulus -> codes 2 then 5. Separately, pulse d = 0x01 at t while pending = 0x80 -> 0 granted before 7.
4. Round-robin: mode = 2, out_rdy = 1, d = 0x81 held every cycle from reset -> out_code sequence 0, 7, 0, 7 ...; with d = 0xFF held -> 0, 1, 2 ... 7, 0.
5. Backpressure: out_rdy = 0, d = 0x08 pulse -> out_vld = 1, out_code = 3 held stable for 5 cycles. A d = 0x02 pulse meanwhile gives pending = 0x02. Raise out_rdy for one edge -> out_code = 1 next, pending = 0.
6. Set-wins collision and mid-reset:
   - pending = 0x10 with load occurring and d = 0x10 on the same edge -> out_code = 4, pending stays 0x10, a second code 4 follows.
   - rst_n low while out_vld = 1 and out_rdy = 0 -> all outputs reset after that edge.

Source files
------------

// File: rtl/prio_enc_hs_if.sv
// Request/grant bundle for prio_enc_hs: request inputs, priority mode,
// the valid/ready code output and the pending/busy status.
interface prio_enc_hs_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic [N-1:0] d;
  logic [1:0]   mode;
  logic [W-1:0] out_code;
  logic         out_vld;
  logic         out_rdy;
  logic [N-1:0] pending;
  logic         busy;

  modport master (
    output d, mode, out_rdy,
    input  out_code, out_vld, pending, busy
  );

  modport slave (
    input  d, mode, out_rdy,
    output out_code, out_vld, pending, busy
  );
endinterface

// File: rtl/prio_enc_hs.sv
// Sticky-request priority encoder: captures request pulses into a pending
// register and hands out one index per cycle through a valid/ready stage.
module prio_enc_hs #(
  parameter int N = 8,
  parameter int W = 3
) (
  input logic         clk,
  input logic         rst_n,
  prio_enc_hs_if.slave bus
);

  if (N < 2 || W != $clog2(N)) begin : g_bad_param
    $error("prio_enc_hs: N must be >= 2 and W must equal clog2(N)");
  end

  logic [N-1:0] pending_q;
  logic [W-1:0] code_q;
  logic         vld_q;
  logic [W-1:0] last_q;

  logic [W-1:0] sel;
  logic         found;
  int           idx;
  logic [N-1:0] grant_mask;
  logic         load;

  // Selection only looks at registered pending, so fresh requests wait a cycle.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    case (bus.mode)
      2'd1: begin
        for (int i = N - 1; i >= 0; i--) begin
          if (pending_q[W'(i)]) sel = W'(i);
        end
      end
      2'd2: begin
        for (int k = 1; k <= N; k++) begin
          idx = (int'(last_q) + k) % N;
          if (!found && pending_q[W'(idx)]) begin
            sel   = W'(idx);
            found = 1'b1;
          end
        end
      end
      default: begin
        for (int i = 0; i < N; i++) begin
          if (pending_q[W'(i)]) sel = W'(i);
        end
      end
    endcase
  end

  assign grant_mask = N'(1) << sel;
  assign load       = (!vld_q || bus.out_rdy) && (pending_q != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      vld_q     <= 1'b0;
      code_q    <= '0;
      last_q    <= W'(N - 1);
    end else if (load) begin
      code_q    <= sel;
      vld_q     <= 1'b1;
      last_q    <= sel;
      // OR-ing d after the clear lets a same-edge request re-arm the granted bit.
      pending_q <= (pending_q & ~grant_mask) | bus.d;
    end else begin
      if (vld_q && bus.out_rdy) vld_q <= 1'b0;
      pending_q <= pending_q | bus.d;
    end
  end

  assign bus.out_code = code_q;
  assign bus.out_vld  = vld_q;
  assign bus.pending  = pending_q;
  assign bus.busy     = vld_q || (pending_q != '0);

endmodule

// File: tb/tb_prio_enc_hs.sv
// Directed bench for prio_enc_hs (N=8): hand-computed codes, pending and
// handshake values checked one cycle at a time.
module tb_prio_enc_hs;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  prio_enc_hs_if #(.N(8), .W(3)) bus ();

  prio_enc_hs #(.N(8), .W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic vld, input logic [2:0] code,
                            input logic [7:0] pend);
    check({tag, ".vld"}, 32'(bus.out_vld), 32'(vld));
    if (vld) check({tag, ".code"}, 32'(bus.out_code), 32'(code));
    check({tag, ".pend"}, 32'(bus.pending), 32'(pend));
    check({tag, ".busy"}, 32'(bus.busy), 32'(vld || (pend != 8'h00)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.d       = 8'hFF;
    bus.mode    = 2'd0;
    bus.out_rdy = 1'b0;

    // Reset ignores d and holds everything at zero
    tick();
    expect_out("rst1", 1'b0, 3'd0, 8'h00);
    check("rst1.code", 32'(bus.out_code), 32'd0);
    tick();
    expect_out("rst2", 1'b0, 3'd0, 8'h00);
    rst_n = 1'b1;
    bus.d = 8'h00;
    tick();
    expect_out("rst_rel", 1'b0, 3'd0, 8'h00);
    check("rst_rel.code", 32'(bus.out_code), 32'd0);

    // Fixed-high
    bus.mode = 2'd0; bus.out_rdy = 1'b1; bus.d = 8'h24;
    tick(); bus.d = 8'h00;
    expect_out("hi.t", 1'b0, 3'd0, 8'h24);
    tick(); expect_out("hi.t1", 1'b1, 3'd5, 8'h04);
    tick(); expect_out("hi.t2", 1'b1, 3'd2, 8'h00);
    tick(); expect_out("hi.t3", 1'b0, 3'd0, 8'h00);

    // Fixed-low
    bus.mode = 2'd1; bus.d = 8'h24;
    tick(); bus.d = 8'h00;
    tick(); expect_out("lo.t1", 1'b1, 3'd2, 8'h20);
    tick(); expect_out("lo.t2", 1'b1, 3'd5, 8'h00);
    tick(); expect_out("lo.t3", 1'b0, 3'd0, 8'h00);

    // Fixed-low: late bit 0 overtakes an older bit 7
    bus.out_rdy = 1'b0; bus.d = 8'h10;
    tick(); bus.d = 8'h00;
    tick(); expect_out("lo2.hold", 1'b1, 3'd4, 8'h00);
    bus.d = 8'h80;
    tick(); expect_out("lo2.p80", 1'b1, 3'd4, 8'h80);
    bus.d = 8'h01;
    tick(); expect_out("lo2.p81", 1'b1, 3'd4, 8'h81);
    bus.d = 8'h00; bus.out_rdy = 1'b1;
    tick(); expect_out("lo2.g0", 1'b1, 3'd0, 8'h80);
    tick(); expect_out("lo2.g7", 1'b1, 3'd7, 8'h00);
    tick(); expect_out("lo2.idle", 1'b0, 3'd0, 8'h00);

    // Mode 3 behaves like mode 0
    bus.mode = 2'd3; bus.d = 8'h24;
    tick(); bus.d = 8'h00;
    tick(); expect_out("m3.t1", 1'b1, 3'd5, 8'h04);
    tick(); expect_out("m3.t2", 1'b1, 3'd2, 8'h00);
    tick();

    // Round-robin, 0x81 held
    bus.mode = 2'd2; bus.out_rdy = 1'b1; bus.d = 8'h00;
    do_reset();
    bus.d = 8'h81;
    tick(); expect_out("rr81.cap", 1'b0, 3'd0, 8'h81);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("rr81.code%0d", i), 32'(bus.out_code), (i % 2 == 0) ? 32'd0 : 32'd7);
      check($sformatf("rr81.vld%0d", i), 32'(bus.out_vld), 32'd1);
    end

    // Round-robin, 0xFF held
    bus.d = 8'h00;
    do_reset();
    bus.d = 8'hFF;
    tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("rrff.code%0d", i), 32'(bus.out_code), 32'(i % 8));
    end

    // Backpressure
    bus.d = 8'h00; bus.mode = 2'd0; bus.out_rdy = 1'b0;
    do_reset();
    bus.d = 8'h08;
    tick(); bus.d = 8'h00;
    tick(); expect_out("bp.load", 1'b1, 3'd3, 8'h00);
    for (int i = 0; i < 5; i++) begin
      bus.d = (i == 1) ? 8'h02 : 8'h00;
      tick();
      check($sformatf("bp.code%0d", i), 32'(bus.out_code), 32'd3);
      check($sformatf("bp.vld%0d", i), 32'(bus.out_vld), 32'd1);
    end
    bus.d = 8'h00;
    check("bp.pend", 32'(bus.pending), 32'h02);
    bus.out_rdy = 1'b1;
    tick(); expect_out("bp.acc", 1'b1, 3'd1, 8'h00);
    bus.out_rdy = 1'b0;
    tick(); expect_out("bp.held", 1'b1, 3'd1, 8'h00);

    // Set wins over clear on the granted bit
    bus.out_rdy = 1'b1;
    do_reset();
    bus.d = 8'h10;
    tick(); expect_out("sw.cap", 1'b0, 3'd0, 8'h10);
    tick(); expect_out("sw.g1", 1'b1, 3'd4, 8'h10);
    bus.d = 8'h00;
    tick(); expect_out("sw.g2", 1'b1, 3'd4, 8'h00);
    tick(); expect_out("sw.idle", 1'b0, 3'd0, 8'h00);

    // Reset mid-transfer
    bus.out_rdy = 1'b0; bus.d = 8'h08;
    tick(); bus.d = 8'h00;
    tick(); expect_out("mr.hold", 1'b1, 3'd3, 8'h00);
    bus.d = 8'h40;
    tick(); expect_out("mr.pend", 1'b1, 3'd3, 8'h40);
    rst_n = 1'b0; bus.d = 8'hFF;
    tick(); expect_out("mr.rst", 1'b0, 3'd0, 8'h00);
    check("mr.rst.code", 32'(bus.out_code), 32'd0);
    rst_n = 1'b1; bus.d = 8'h00;
    tick(); expect_out("mr.rel", 1'b0, 3'd0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
